exc_req_sequencer: RTL and testbench
====================================

// Module: exc_req_sequencer
// PURPOSE
// - Collects exception/interrupt requests from NSRC sources and latches them as pending.
// - Picks the highest-priority unmasked pending source. Raises Exc to the exception unit.
// - Drives EStatus with the cause code. Waits for ExcAck (PC reached the exception vector).
// - Then blocks new exceptions until the handler executes ERET, so exceptions do not nest.
// PARAMETERS
// - NSRC         4   number of request sources, 1..15; index 0 has the highest priority
// - ACK_TIMEOUT  64  cycles allowed in REQ without ExcAck (only used with EXC_TIMEOUT_EN)
// PORTS
// - clk          in   1     single clock; all state updates on the rising edge
// - reset        in   1     asynchronous, active-low reset (0 = reset asserted)
// - exc_req      in   NSRC  per-source request lines; rising-edge sensitive
// - exc_mask     in   NSRC  1 = source disabled; it may still latch but is never selected
// - exc_en       in   1     global enable; 0 = remain in IDLE, pending bits kept
// - ExcAck       in   1     exception unit has fetched the vector address
// - ERet         in   1     ERET resolved in E stage (the same signal that selects ERR for PCBranch)
// - Exc          out  1     exception request to the exception unit
// - EStatus      out  4     cause code: source index + 1; 0 = none
// - pending      out  NSRC  latched, unserviced requests
// - busy         out  1     1 in REQ or HANDLER
// - timeout_err  out  1     sticky flag: ACK timeout has occurred
// BEHAVIOUR
// - Reset (async, reset=0):
//   - state=IDLE; Exc=0, EStatus=0, pending=0, busy=0, timeout_err=0.
//   - Edge-detect registers are cleared to 0, so a request held high through reset counts as a rising edge.
// - Edge detect: req_q <= exc_req. pending[i] is set on the edge where exc_req[i] & ~req_q[i].
// - Pending clear: pending[sel] is cleared on the edge where ExcAck is sampled in REQ.
//   If set and clear hit the same bit on the same edge, set wins.
// - Select: sel = lowest i with pending[i] & ~exc_mask[i]. Combinational from registers only.
// - FSM (all outputs registered):
//   - IDLE: busy=0, Exc=0.
//     - If exc_en and an eligible pending bit exists: go to REQ.
//     - On that edge: Exc<=1, EStatus<=sel+1, cur<=sel.
//   - REQ: Exc=1; EStatus and cur are frozen.
//     - ExcAck=1: go to HANDLER; Exc<=0; clear pending[cur].
//     - Mask or exc_en changes here are ignored; the request is already committed.
//   - HANDLER: Exc=0; EStatus held for the handler's ESR read.
//     - ERet=1: go to IDLE; EStatus<=0.
//     - New requests keep latching into pending.
// - Latency:
//   - Request edge sampled at edge n sets pending at n.
//   - Exc=1 is visible after edge n+1.
//   - After ERet, the next exception needs at least 1 cycle in IDLE before Exc rises again.
// - Ignored events:
//   - ERet in IDLE or REQ.
//   - ExcAck in IDLE or HANDLER.
//   - If ExcAck and ERet arrive together in REQ, only ExcAck acts.
// - Several requests on the same edge: all latch; they are serviced in priority order, one per ERET.
// - Re-request of the source currently in HANDLER: latches again and is serviced after ERET.
// - Reset mid-operation: immediate return to the reset state; all pending requests are lost.
// CONFIGURATION
// - EXC_TIMEOUT_EN defined:
//   - A counter runs in REQ.
//   - After ACK_TIMEOUT cycles without ExcAck: Exc<=0, state<=IDLE, timeout_err<=1 (sticky until reset).
//   - pending[cur] is kept, so the request retries from IDLE.
// - EXC_TIMEOUT_EN undefined:
//   - REQ waits indefinitely.
//   - No counter is built; timeout_err is tied to 0.
// TESTING
// 1. Reset with exc_req=0 -> Exc=0, EStatus=0, pending=0, busy=0.
// 2. Single source:
//    - Pulse exc_req[2] -> pending=4'b0100, Exc=1 one cycle later, EStatus=3.
//    - ExcAck -> Exc=0, pending=0.
//    - ERet -> busy=0.
// 3. exc_req=4'b1010 on the same edge ->
//    - First exception has EStatus=2.
//    - After ERet and one IDLE cycle, the second has EStatus=4.
// 4. Masking:
//    - exc_mask=4'b0001 while exc_req[0] rises -> pending[0]=1, Exc stays 0.
//    - Clear the mask -> Exc=1, EStatus=1.
// 5. Spurious inputs: ERet in IDLE and ExcAck in HANDLER -> no state change.
//    Drive reset=0 while in HANDLER -> all outputs return to 0 asynchronously.
// 6. EXC_TIMEOUT_EN, ACK_TIMEOUT=8: no ExcAck ->
//    - Exc drops after 8 cycles and timeout_err=1.
//    - Exc re-asserts with the same EStatus.
//    - Without the macro: Exc stays 1 for 100 cycles.

Source files
------------

// File: rtl/exc_req_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : exc_req_sequencer_if
//  Description : Request/acknowledge bundle between the exception request
//                sequencer and the surrounding pipeline / exception unit.
//                master : drives requests, masks, enable, ExcAck, ERet
//                slave  : the sequencer; drives Exc, EStatus, pending,
//                         busy, timeout_err
//  Signals     : exc_req[NSRC]  per-source request lines (rising edge)
//                exc_mask[NSRC] 1 = source never selected
//                exc_en         global enable
//                ExcAck         exception unit fetched the vector
//                ERet           ERET resolved in E stage
//                Exc            exception request
//                EStatus[4]     cause code (source index + 1, 0 = none)
//                pending[NSRC]  latched, unserviced requests
//                busy           sequencer in REQ or HANDLER
//                timeout_err    sticky ACK-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface exc_req_sequencer_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] exc_req;
    logic [NSRC-1:0] exc_mask;
    logic            exc_en;
    logic            ExcAck;
    logic            ERet;
    logic            Exc;
    logic [3:0]      EStatus;
    logic [NSRC-1:0] pending;
    logic            busy;
    logic            timeout_err;

    modport master (
        output exc_req, exc_mask, exc_en, ExcAck, ERet,
        input  Exc, EStatus, pending, busy, timeout_err
    );

    modport slave (
        input  exc_req, exc_mask, exc_en, ExcAck, ERet,
        output Exc, EStatus, pending, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/exc_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exc_req_sequencer
//  Description : Latches rising-edge exception requests from NSRC sources,
//                raises Exc for the highest-priority (lowest index) unmasked
//                pending source, waits for ExcAck, then blocks further
//                exceptions until ERet so handlers never nest.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous, active-low reset
//                bus    - exc_req_sequencer_if.slave (requests in, Exc /
//                         EStatus / pending / busy / timeout_err out)
//  Options     : EXC_TIMEOUT_EN - when defined, REQ gives up after
//                ACK_TIMEOUT cycles without ExcAck, sets the sticky
//                timeout_err and retries from IDLE (pending bit kept).
//                When undefined, REQ waits forever and timeout_err = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_req_sequencer #(
    parameter int NSRC        = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    exc_req_sequencer_if.slave bus
);

    // Cause code is 4 bits wide (index + 1), so at most 15 sources.
    if (NSRC < 1 || NSRC > 15 || ACK_TIMEOUT < 1) begin : g_param_check
        $error("exc_req_sequencer: NSRC must be 1..15 and ACK_TIMEOUT >= 1");
    end

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HANDLER = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [NSRC-1:0] r_req_q;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic [3:0]      r_cur;
    logic [3:0]      w_sel;
    logic            w_sel_valid;
    logic            w_go;
    logic            w_ack_take;
    logic            w_timeout;
    logic            r_exc;
    logic            w_exc_nxt;
    logic [3:0]      r_estatus;
    logic [3:0]      w_estatus_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_timeout_err;

    // ------------------------------------------------------------------
    // Priority select: lowest eligible index wins (scan from the top so
    // the last match, i.e. the lowest index, sticks).
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = 4'd0;
        w_sel_valid = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (r_pending[i] && !bus.exc_mask[i]) begin
                w_sel       = 4'(i);
                w_sel_valid = 1'b1;
            end
        end
    end

    assign w_go       = (r_state == S_IDLE) && bus.exc_en && w_sel_valid;
    assign w_ack_take = (r_state == S_REQ) && bus.ExcAck;
    assign w_set      = bus.exc_req & ~r_req_q;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_clr[i] = w_ack_take && (r_cur == 4'(i));
        end
    end

    // ------------------------------------------------------------------
    // Optional ACK timeout. The counter is cleared outside REQ so each
    // attempt gets the full ACK_TIMEOUT cycles of Exc high.
    // ------------------------------------------------------------------
`ifdef EXC_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] r_tcnt;

    assign w_timeout = (r_state == S_REQ) && !bus.ExcAck &&
                       (r_tcnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_REQ || bus.ExcAck || w_timeout) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout     = 1'b0;
    assign r_timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register (plus the registered outputs it feeds)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_req_q   <= '0;
            r_pending <= '0;
            r_cur     <= 4'd0;
            r_exc     <= 1'b0;
            r_estatus <= 4'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= bus.exc_req;
            // A new edge on the bit being acknowledged survives the clear.
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_exc     <= w_exc_nxt;
            r_estatus <= w_estatus_nxt;
            r_busy    <= w_busy_nxt;
            if (w_go) begin
                r_cur <= w_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // ExcAck takes precedence over a coincident timeout or ERet.
                if (bus.ExcAck)   w_state_nxt = S_HANDLER;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_HANDLER: begin
                if (bus.ERet) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_exc_nxt     = r_exc;
        w_estatus_nxt = r_estatus;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_exc_nxt = w_go;
                if (w_go) w_estatus_nxt = w_sel + 4'd1;
            end
            S_REQ: begin
                if (bus.ExcAck) begin
                    w_exc_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_exc_nxt     = 1'b0;
                    w_estatus_nxt = 4'd0;
                end
            end
            S_HANDLER: begin
                w_exc_nxt = 1'b0;
                // EStatus stays valid until ERet for the handler's ESR read.
                if (bus.ERet) w_estatus_nxt = 4'd0;
            end
            default: begin
                w_exc_nxt     = 1'b0;
                w_estatus_nxt = 4'd0;
            end
        endcase
    end

    assign bus.Exc         = r_exc;
    assign bus.EStatus     = r_estatus;
    assign bus.pending     = r_pending;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_exc_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_req_sequencer
//  Description : Directed, table-driven self-checking bench for
//                exc_req_sequencer (NSRC=4, ACK_TIMEOUT=8), plus
//                hand-written sequences for async reset and ACK timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_req_sequencer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    exc_req_sequencer_if #(.NSRC(4)) bus ();

    exc_req_sequencer #(
        .NSRC        (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       en;
        logic       ack;
        logic       eret;
        logic       exc;
        logic [3:0] es;
        logic [3:0] pend;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //            req      mask     en    ack   eret  | exc   es     pend     busy
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b0,4'd0,4'b0000,1'b0}); // 0 idle
        tbl.push_back('{4'b0100,4'b0000,1'b1,1'b0,1'b0, 1'b0,4'd0,4'b0100,1'b0}); // 1 latch src2
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd3,4'b0100,1'b1}); // 2 Exc rises
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b1,4'd3,4'b0100,1'b1}); // 3 ERet in REQ ignored
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b0, 1'b0,4'd3,4'b0000,1'b1}); // 4 ack -> HANDLER
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b0, 1'b0,4'd3,4'b0000,1'b1}); // 5 ack in HANDLER ignored
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b0,4'd0,4'b0000,1'b0}); // 6 ERet -> IDLE
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b1, 1'b0,4'd0,4'b0000,1'b0}); // 7 ack/ERet in IDLE ignored
        tbl.push_back('{4'b1010,4'b0000,1'b1,1'b0,1'b0, 1'b0,4'd0,4'b1010,1'b0}); // 8 two at once
        tbl.push_back('{4'b1010,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd2,4'b1010,1'b1}); // 9 src1 first
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b1, 1'b0,4'd2,4'b1000,1'b1}); // 10 ack+ERet: ack only
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b0,4'd2,4'b1000,1'b1}); // 11 hold
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b0,4'd0,4'b1000,1'b0}); // 12 ERet
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd4,4'b1000,1'b1}); // 13 src3 after idle cycle
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b0, 1'b0,4'd4,4'b0000,1'b1}); // 14 ack
        tbl.push_back('{4'b1000,4'b0000,1'b1,1'b0,1'b0, 1'b0,4'd4,4'b1000,1'b1}); // 15 re-request current src
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b0,4'd0,4'b1000,1'b0}); // 16 ERet
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd4,4'b1000,1'b1}); // 17 serviced again
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b0, 1'b0,4'd4,4'b0000,1'b1}); // 18 ack
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b0,4'd0,4'b0000,1'b0}); // 19 ERet
        tbl.push_back('{4'b0001,4'b0001,1'b1,1'b0,1'b0, 1'b0,4'd0,4'b0001,1'b0}); // 20 masked latch
        tbl.push_back('{4'b0000,4'b0001,1'b1,1'b0,1'b0, 1'b0,4'd0,4'b0001,1'b0}); // 21 stays masked
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd1,4'b0001,1'b1}); // 22 unmask -> Exc
        tbl.push_back('{4'b0000,4'b0001,1'b0,1'b0,1'b0, 1'b1,4'd1,4'b0001,1'b1}); // 23 mask/en ignored in REQ
        tbl.push_back('{4'b0000,4'b0001,1'b0,1'b1,1'b0, 1'b0,4'd1,4'b0000,1'b1}); // 24 ack
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b0,4'd0,4'b0000,1'b0}); // 25 ERet
        tbl.push_back('{4'b0100,4'b0000,1'b0,1'b0,1'b0, 1'b0,4'd0,4'b0100,1'b0}); // 26 disabled latch
        tbl.push_back('{4'b0000,4'b0000,1'b0,1'b0,1'b0, 1'b0,4'd0,4'b0100,1'b0}); // 27 stays IDLE
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd3,4'b0100,1'b1}); // 28 enable -> Exc
        tbl.push_back('{4'b0100,4'b0000,1'b1,1'b1,1'b0, 1'b0,4'd3,4'b0100,1'b1}); // 29 set beats clear
        tbl.push_back('{4'b0101,4'b0000,1'b1,1'b0,1'b0, 1'b0,4'd3,4'b0101,1'b1}); // 30 latch in HANDLER
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b1, 1'b0,4'd0,4'b0101,1'b0}); // 31 ERet
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b0,1'b0, 1'b1,4'd1,4'b0101,1'b1}); // 32 src0 first
        tbl.push_back('{4'b0000,4'b0000,1'b1,1'b1,1'b0, 1'b0,4'd1,4'b0100,1'b1}); // 33 ack

        // Reset with everything quiet
        reset        = 1'b0;
        bus.exc_req  = 4'b0000;
        bus.exc_mask = 4'b0000;
        bus.exc_en   = 1'b1;
        bus.ExcAck   = 1'b0;
        bus.ERet     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset Exc",         32'(bus.Exc),         32'd0);
        check("reset EStatus",     32'(bus.EStatus),     32'd0);
        check("reset pending",     32'(bus.pending),     32'd0);
        check("reset busy",        32'(bus.busy),        32'd0);
        check("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus.exc_req  = tbl[i].req;
            bus.exc_mask = tbl[i].mask;
            bus.exc_en   = tbl[i].en;
            bus.ExcAck   = tbl[i].ack;
            bus.ERet     = tbl[i].eret;
            @(posedge clk);
            #1;
            check($sformatf("row%0d Exc", i),     32'(bus.Exc),         32'(tbl[i].exc));
            check($sformatf("row%0d EStatus", i), 32'(bus.EStatus),     32'(tbl[i].es));
            check($sformatf("row%0d pending", i), 32'(bus.pending),     32'(tbl[i].pend));
            check($sformatf("row%0d busy", i),    32'(bus.busy),        32'(tbl[i].busy));
            check($sformatf("row%0d terr", i),    32'(bus.timeout_err), 32'd0);
        end

        // Async reset while in HANDLER, with a request held high through it
        @(negedge clk);
        bus.exc_req = 4'b0001;
        bus.ExcAck  = 1'b0;
        bus.ERet    = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async Exc",     32'(bus.Exc),     32'd0);
        check("async EStatus", 32'(bus.EStatus), 32'd0);
        check("async pending", 32'(bus.pending), 32'd0);
        check("async busy",    32'(bus.busy),    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset edge pending", 32'(bus.pending), 32'b0001);
        check("post-reset edge Exc",     32'(bus.Exc),     32'd0);
        @(posedge clk);
        #1;
        check("post-reset Exc",     32'(bus.Exc),     32'd1);
        check("post-reset EStatus", 32'(bus.EStatus), 32'd1);

        // No ExcAck: timeout (when built) or indefinite wait
        begin : g_wait_ack
            int hi;
            hi = 1;
`ifdef EXC_TIMEOUT_EN
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (bus.Exc) hi++;
                else break;
            end
            check("timeout Exc cycles", 32'(hi),              32'd8);
            check("timeout_err set",    32'(bus.timeout_err), 32'd1);
            check("timeout pending",    32'(bus.pending),     32'b0001);
            check("timeout busy",       32'(bus.busy),        32'd0);
            @(posedge clk);
            #1;
            check("retry Exc",     32'(bus.Exc),         32'd1);
            check("retry EStatus", 32'(bus.EStatus),     32'd1);
            check("retry terr",    32'(bus.timeout_err), 32'd1);
`else
            repeat (99) begin
                @(posedge clk);
                #1;
                if (bus.Exc) hi++;
            end
            check("no-timeout Exc cycles", 32'(hi),              32'd100);
            check("no-timeout EStatus",    32'(bus.EStatus),     32'd1);
            check("no-timeout terr",       32'(bus.timeout_err), 32'd0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
